// File: rtl/qam_bit_packer.sv
// qam_bit_packer: packs decoded QAM I/Q codes MSB-first into OUT_WIDTH-bit words
// and streams them out through a small first-word-fall-through FIFO.
module qam_bit_packer #(
    parameter int MODULATION_ORDER = 16,
    parameter int OUT_WIDTH        = 8,
    parameter int FIFO_DEPTH       = 4,
    localparam int BW              = $clog2(MODULATION_ORDER) / 2,
    localparam int LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BW-1:0]        i_binary,
    input  logic [BW-1:0]        q_binary,
    input  logic                 dv,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 overflow
);

    localparam int K     = 2 * BW;
    localparam int ACC_W = OUT_WIDTH + K - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    logic [ACC_W-1:0]     acc_r, acc_nxt_s, abs_acc_s, base_acc_s, sym_top_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s, abs_cnt_s, base_cnt_s;
    logic                 pend_r, pend_nxt_s, push_s;
    logic [OUT_WIDTH-1:0] push_word_s;

    logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [LVL_W-1:0]     level_r, level_nxt_s;
    logic                 pop_s, wr_en_s, full_s, drop_s;
    logic [OUT_WIDTH-1:0] head_nxt_s, m_data_r;
    logic                 m_valid_r, overflow_r;

    // Accumulator: optional deferred flush, symbol append, word extraction, flush padding.
    always_comb begin
        sym_top_s   = ACC_W'({i_binary, q_binary}) << (ACC_W - K);
        base_acc_s  = acc_r;
        base_cnt_s  = cnt_r;
        push_s      = 1'b0;
        push_word_s = {OUT_WIDTH{1'b0}};
        pend_nxt_s  = 1'b0;
        // A deferred flush drains the old bits before this cycle's symbol lands.
        if (pend_r) begin
            push_s      = 1'b1;
            push_word_s = acc_r[ACC_W-1 -: OUT_WIDTH];
            base_acc_s  = {ACC_W{1'b0}};
            base_cnt_s  = {CNT_W{1'b0}};
        end else begin
            base_acc_s  = acc_r;
            base_cnt_s  = cnt_r;
        end
        if (dv) begin
            abs_acc_s = base_acc_s | (sym_top_s >> base_cnt_s);
            abs_cnt_s = base_cnt_s + CNT_W'(K);
        end else begin
            abs_acc_s = base_acc_s;
            abs_cnt_s = base_cnt_s;
        end
        if (abs_cnt_s >= CNT_W'(OUT_WIDTH)) begin
            push_s      = 1'b1;
            push_word_s = abs_acc_s[ACC_W-1 -: OUT_WIDTH];
            acc_nxt_s   = abs_acc_s << OUT_WIDTH;
            cnt_nxt_s   = abs_cnt_s - CNT_W'(OUT_WIDTH);
        end else begin
            acc_nxt_s   = abs_acc_s;
            cnt_nxt_s   = abs_cnt_s;
        end
        if (flush && (cnt_nxt_s != {CNT_W{1'b0}})) begin
            if (push_s) begin
                pend_nxt_s = 1'b1;
            end else begin
                push_s      = 1'b1;
                push_word_s = acc_nxt_s[ACC_W-1 -: OUT_WIDTH];
                acc_nxt_s   = {ACC_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        end else begin
            pend_nxt_s = 1'b0;
        end
    end

    // Accumulator state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r  <= {ACC_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            pend_r <= 1'b0;
        end else begin
            acc_r  <= acc_nxt_s;
            cnt_r  <= cnt_nxt_s;
            pend_r <= pend_nxt_s;
        end
    end

    // FIFO control: push/pop arbitration, level update and next head word.
    always_comb begin
        pop_s       = m_valid_r && m_ready;
        full_s      = (level_r == LVL_W'(FIFO_DEPTH));
        wr_en_s     = push_s && (!full_s || pop_s);
        drop_s      = push_s && !wr_en_s;
        level_nxt_s = level_r;
        case ({wr_en_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        // The word written this cycle becomes the head when the FIFO drains to it.
        if (wr_en_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = push_word_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_r[e] <= {OUT_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end else begin
            mem_r <= mem_r;
        end
    end

    // FIFO pointers, level, registered stream outputs and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            m_valid_r  <= 1'b0;
            m_data_r   <= {OUT_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_nxt_s;
            level_r    <= level_nxt_s;
            m_valid_r  <= (level_nxt_s != {LVL_W{1'b0}});
            m_data_r   <= head_nxt_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign m_data     = m_data_r;
    assign m_valid    = m_valid_r;
    assign fifo_level = level_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_qam_bit_packer.sv
// Bench for qam_bit_packer: directed vector table, an M=64 packing sequence and
// randomized traffic checked against a bit-queue reference model.
module tb_qam_bit_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst16, dv16, fl16, rdy16, v16, ovf16;
    logic [1:0] i16, q16;
    logic [7:0] d16;
    logic [2:0] lvl16;

    logic       rst64, dv64, fl64, rdy64, v64, ovf64;
    logic [2:0] i64, q64;
    logic [7:0] d64;
    logic [2:0] lvl64;

    qam_bit_packer #(.MODULATION_ORDER(16), .OUT_WIDTH(8), .FIFO_DEPTH(4)) dut16 (
        .clk(clk), .rst(rst16), .i_binary(i16), .q_binary(q16), .dv(dv16), .flush(fl16),
        .m_data(d16), .m_valid(v16), .m_ready(rdy16), .fifo_level(lvl16), .overflow(ovf16));

    qam_bit_packer #(.MODULATION_ORDER(64), .OUT_WIDTH(8), .FIFO_DEPTH(4)) dut64 (
        .clk(clk), .rst(rst64), .i_binary(i64), .q_binary(q64), .dv(dv64), .flush(fl64),
        .m_data(d64), .m_valid(v64), .m_ready(rdy64), .fifo_level(lvl64), .overflow(ovf64));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit       r;
        bit       dv;
        bit [3:0] sym;
        bit       fl;
        bit       rdy;
        bit       ev;
        bit       cd;
        bit [7:0] ed;
        int       el;
        bit       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit dv, bit [3:0] sym, bit fl, bit rdy,
                                bit ev, bit cd, bit [7:0] ed, int el, bit eo);
        vec_t v;
        v.r = r; v.dv = dv; v.sym = sym; v.fl = fl; v.rdy = rdy;
        v.ev = ev; v.cd = cd; v.ed = ed; v.el = el; v.eo = eo;
        vecs.push_back(v);
    endfunction

    // Reference model: stream of pending bits plus a queue of FIFO words.
    bit         bq[$];
    logic [7:0] fq[$];
    bit         m_pend, m_ovf;

    function automatic logic [7:0] take_word();
        logic [7:0] w = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (bq.size() > 0) w[7-b] = bq.pop_front();
        end
        return w;
    endfunction

    function automatic void model_step(bit r, bit dv, bit [3:0] sym, bit fl, bit rdy);
        bit         produced = 1'b0;
        bit         pop;
        logic [7:0] w = 8'h00;
        if (r) begin
            bq.delete(); fq.delete(); m_pend = 1'b0; m_ovf = 1'b0;
            return;
        end
        pop = (fq.size() > 0) && rdy;
        if (m_pend) begin
            w = take_word(); produced = 1'b1; m_pend = 1'b0;
        end
        if (dv) begin
            for (int b = 3; b >= 0; b--) bq.push_back(sym[b]);
        end
        if (bq.size() >= 8) begin
            w = take_word(); produced = 1'b1;
        end
        if (fl && bq.size() > 0) begin
            if (produced) m_pend = 1'b1;
            else begin
                w = take_word(); produced = 1'b1;
            end
        end
        if (pop) void'(fq.pop_front());
        if (produced) begin
            if (fq.size() < 4) fq.push_back(w);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic step64(input bit [5:0] sym, input bit dv);
        i64 = sym[5:3]; q64 = sym[2:0]; dv64 = dv;
        @(posedge clk); #1;
    endtask

    initial begin
        rst16 = 1'b1; dv16 = 1'b0; fl16 = 1'b0; rdy16 = 1'b1; i16 = 2'b00; q16 = 2'b00;
        rst64 = 1'b1; dv64 = 1'b0; fl64 = 1'b0; rdy64 = 1'b1; i64 = 3'b000; q64 = 3'b000;
        @(posedge clk); #1;
        rst64 = 1'b0;

        // Reset state, then basic pack (9C)
        add(1, 0, 4'h0, 0, 1, 0, 1, 8'h00, 0, 0);
        add(0, 1, 4'h9, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 4'hC, 0, 1, 1, 1, 8'h9C, 1, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 8'h00, 0, 0);
        // Flush of a partial word, empty flush, dv+flush completing a word
        add(0, 1, 4'hD, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 0, 4'h0, 1, 1, 1, 1, 8'hD0, 1, 0);
        add(0, 0, 4'h0, 1, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 4'h6, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 4'hF, 1, 1, 1, 1, 8'h6F, 1, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 8'h00, 0, 0);
        // Fill under backpressure: fifth word dropped, then drain
        for (int n = 1; n <= 10; n++)
            add(0, 1, 4'(n), 0, 0, n >= 2, n >= 2, 8'h12, (n / 2 > 4) ? 4 : n / 2, n == 10);
        add(0, 0, 4'h0, 0, 1, 1, 1, 8'h34, 3, 1);
        add(0, 0, 4'h0, 0, 1, 1, 1, 8'h56, 2, 1);
        add(0, 0, 4'h0, 0, 1, 1, 1, 8'h78, 1, 1);
        add(0, 0, 4'h0, 0, 1, 0, 0, 8'h00, 0, 1);
        // Reset mid-word discards partial bits and clears overflow
        add(0, 1, 4'hF, 0, 1, 0, 0, 8'h00, 0, 1);
        add(1, 0, 4'h0, 0, 1, 0, 1, 8'h00, 0, 0);
        add(0, 1, 4'h6, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 4'h9, 0, 1, 1, 1, 8'h69, 1, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 8'h00, 0, 0);
        // Full FIFO with simultaneous push and pop: no drop
        add(1, 0, 4'h0, 0, 1, 0, 1, 8'h00, 0, 0);
        for (int n = 1; n <= 9; n++)
            add(0, 1, 4'(n), 0, 0, n >= 2, n >= 2, 8'h12, (n / 2 > 4) ? 4 : n / 2, 0);
        add(0, 1, 4'hA, 0, 1, 1, 1, 8'h34, 4, 0);
        add(0, 0, 4'h0, 0, 1, 1, 1, 8'h56, 3, 0);
        add(0, 0, 4'h0, 0, 1, 1, 1, 8'h78, 2, 0);
        add(0, 0, 4'h0, 0, 1, 1, 1, 8'h9A, 1, 0);
        add(0, 0, 4'h0, 0, 1, 0, 0, 8'h00, 0, 0);

        foreach (vecs[k]) begin
            rst16 = vecs[k].r; dv16 = vecs[k].dv; fl16 = vecs[k].fl; rdy16 = vecs[k].rdy;
            i16 = vecs[k].sym[3:2]; q16 = vecs[k].sym[1:0];
            @(posedge clk); #1;
            check($sformatf("vec%0d.valid", k), v16, vecs[k].ev);
            check($sformatf("vec%0d.level", k), lvl16, vecs[k].el);
            check($sformatf("vec%0d.overflow", k), ovf16, vecs[k].eo);
            if (vecs[k].cd) check($sformatf("vec%0d.data", k), d16, vecs[k].ed);
        end
        rst16 = 1'b0; dv16 = 1'b0; fl16 = 1'b0;

        // M=64 packing across word boundaries: FC, 0A, 95
        rdy64 = 1'b1;
        step64(6'o77, 1'b1);
        check("m64.first_idle", v64, 1'b0);
        step64(6'o00, 1'b1);
        check("m64.w0.valid", v64, 1'b1);
        check("m64.w0.data", d64, 8'hFC);
        step64(6'b101010, 1'b1);
        check("m64.w1.valid", v64, 1'b1);
        check("m64.w1.data", d64, 8'h0A);
        step64(6'b010101, 1'b1);
        check("m64.w2.valid", v64, 1'b1);
        check("m64.w2.data", d64, 8'h95);
        step64(6'o00, 1'b0);
        check("m64.drained", v64, 1'b0);
        check("m64.overflow", ovf64, 1'b0);

        // Randomized traffic against the reference model
        rst16 = 1'b1; model_step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst16 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit       r, dv, fl, rdy;
            bit [3:0] sym;
            r   = ($urandom_range(0, 299) == 0);
            dv  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ((c / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            sym = 4'($urandom_range(0, 15));
            rst16 = r; dv16 = dv; fl16 = fl; rdy16 = rdy; i16 = sym[3:2]; q16 = sym[1:0];
            model_step(r, dv, sym, fl, rdy);
            @(posedge clk); #1;
            check($sformatf("rnd%0d.valid", c), v16, fq.size() > 0);
            check($sformatf("rnd%0d.level", c), lvl16, fq.size());
            check($sformatf("rnd%0d.overflow", c), ovf16, m_ovf);
            if (fq.size() > 0) check($sformatf("rnd%0d.data", c), d16, fq[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
